inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Decoupling instruction queue between the prefetch unit (PFU) and the decode stage (DPU).
- Buffers up to DEPTH {inst, pc} pairs so AHB fetch latency and decode stalls do not stall each other.
- Valid/ready handshake on both sides; a control flush discards all buffered entries.
- Registered storage; no combinational data path from input to output.

Parameters:
- DEPTH, 4, number of entries; power of 2, >= 2.
- INST_WIDTH, 32, instruction width.
- PC_WIDTH, 32, program-counter width.
- CNT_WIDTH, 3, occupancy width = log2(DEPTH)+1.

Ports:
- clk_i  input  1  clock; all state on rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- pfu2ifq_valid_i  input  1  PFU offers an instruction.
- pfu2ifq_inst_i  input  INST_WIDTH  offered instruction.
- pfu2ifq_pc_i  input  PC_WIDTH  PC of offered instruction.
- ifq2pfu_ready_o  output  1  queue accepts this cycle.
- ifq2dpu_valid_o  output  1  head entry available.
- ifq2dpu_inst_o  output  INST_WIDTH  head instruction.
- ifq2dpu_pc_o  output  PC_WIDTH  head PC.
- dpu2ifq_ready_i  input  1  DPU consumes head this cycle.
- ctrl2ifq_flush_i  input  1  discard all entries.
- ifq2ctrl_empty_o  output  1  queue empty.
- ifq2ctrl_count_o  output  CNT_WIDTH  current occupancy, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH {inst, pc} entries; storage is not reset.
- Pointers: wr_ptr and rd_ptr, each log2(DEPTH)+1 bits (MSB is the wrap bit).
  - empty = (wr_ptr == rd_ptr).
  - full = low bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^CNT_WIDTH.
- Reset (rst_i high at clock edge):
  - wr_ptr = rd_ptr = 0; ifq2dpu_valid_o = 0; ifq2dpu_inst_o = 0; ifq2dpu_pc_o = 0.
  - ifq2pfu_ready_o = 1; ifq2ctrl_empty_o = 1; ifq2ctrl_count_o = 0.
  - Reset mid-operation drops all entries identically; rst_i has priority over flush, push and pop.
- Output equations:
  - ifq2pfu_ready_o = ~full & ~ctrl2ifq_flush_i.
  - ifq2dpu_valid_o = ~empty & ~ctrl2ifq_flush_i.
  - ifq2dpu_inst_o / ifq2dpu_pc_o = entry[rd_ptr] when ~empty, else 0.
- Push: pfu2ifq_valid_i & ifq2pfu_ready_o. Writes entry[wr_ptr]; wr_ptr+1 at the edge.
- Pop: ifq2dpu_valid_o & dpu2ifq_ready_i. rd_ptr+1 at the edge.
- Latency: an entry pushed at edge N is visible on the DPU side from cycle N+1. No fall-through; an empty queue never presents the input in the same cycle.
- Simultaneous push and pop (not full, not empty): both occur; count unchanged.
- Full: ready low, so there is no push even if a pop occurs that cycle. Ready rises the cycle after the pop (no same-cycle refill).
- Empty: valid low, so no pop. dpu2ifq_ready_i is ignored.
- Flush:
  - Both handshakes are masked in the flush cycle.
  - At the edge, rd_ptr <= wr_ptr, so the queue becomes empty.
  - The input offered in the flush cycle is dropped.
  - In the cycle after flush the queue is empty with ready = 1; a new push is accepted then.
- Wrap-around: pointers wrap modulo 2*DEPTH; the order of {inst, pc} is strictly FIFO across wraps.
- Handshake rules:
  - Upstream may drop pfu2ifq_valid_i without a handshake.
  - Downstream head data is stable while valid & ~ready, until pop or flush.

Decomposition:
- Shared package holds INST_WIDTH, PC_WIDTH, INIT_PC and the NOP encoding (32'h0000_0013), common with PFU/DPU.
- No sub-module: pointer logic and the register array fit in one module.

Test Plan:
- Reset then idle, dpu ready = 1 -> valid = 0, empty = 1, count = 0, ready = 1, inst/pc outputs = 0.
- Push {0x00000013, 0x80000000}, dpu ready = 0 -> cycle+1: valid = 1, inst = 0x13, pc = 0x80000000, count = 1; raise dpu ready -> cycle+1: empty = 1.
- Push 4 entries (pc 0x0, 0x4, 0x8, 0xC) with dpu ready = 0 -> count = 4, ready = 0; a 5th offer (pc 0x10) stays unaccepted; one pop -> next cycle ready = 1, then 0x10 is accepted; drain order is 0x4, 0x8, 0xC, 0x10.
- Continuous push and pop for 10 instructions (pc 0x0..0x24) -> count holds at 1 and pc order is preserved across two pointer wraps.
- Fill 3 entries, assert flush while pushing pc 0x20 and dpu ready = 1 -> no pop and no push; next cycle count = 0, valid = 0, ready = 1; pc 0x20 never appears at the output.
- Fill 2 entries, assert rst_i together with push and flush -> next cycle all outputs are at reset values.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the fetch path (PFU, instruction queue, DPU).
package inst_fetch_queue_pkg;

    localparam int unsigned IFQ_INST_WIDTH = 32;
    localparam int unsigned IFQ_PC_WIDTH   = 32;

    localparam logic [IFQ_PC_WIDTH-1:0]   INIT_PC  = 32'h8000_0000;
    localparam logic [IFQ_INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [IFQ_INST_WIDTH-1:0] inst;
        logic [IFQ_PC_WIDTH-1:0]   pc;
    } ifq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Decoupling FIFO of {inst, pc} pairs between prefetch and decode, with flush.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned INST_WIDTH = IFQ_INST_WIDTH,
    parameter int unsigned PC_WIDTH   = IFQ_PC_WIDTH,
    parameter int unsigned CNT_WIDTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pfu2ifq_valid_i,
    input  logic [INST_WIDTH-1:0] pfu2ifq_inst_i,
    input  logic [PC_WIDTH-1:0]   pfu2ifq_pc_i,
    output logic                  ifq2pfu_ready_o,
    output logic                  ifq2dpu_valid_o,
    output logic [INST_WIDTH-1:0] ifq2dpu_inst_o,
    output logic [PC_WIDTH-1:0]   ifq2dpu_pc_o,
    input  logic                  dpu2ifq_ready_i,
    input  logic                  ctrl2ifq_flush_i,
    output logic                  ifq2ctrl_empty_o,
    output logic [CNT_WIDTH-1:0]  ifq2ctrl_count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [INST_WIDTH-1:0] inst_mem [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem   [DEPTH];

    logic empty_c;
    logic full_c;
    logic push_c;
    logic pop_c;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign ifq2pfu_ready_o = ~full_c & ~ctrl2ifq_flush_i;
    assign ifq2dpu_valid_o = ~empty_c & ~ctrl2ifq_flush_i;

    assign push_c = pfu2ifq_valid_i & ifq2pfu_ready_o;
    assign pop_c  = ifq2dpu_valid_o & dpu2ifq_ready_i;

    assign ifq2dpu_inst_o   = empty_c ? '0 : inst_mem[rd_ptr[AW-1:0]];
    assign ifq2dpu_pc_o     = empty_c ? '0 : pc_mem[rd_ptr[AW-1:0]];
    assign ifq2ctrl_empty_o = empty_c;
    assign ifq2ctrl_count_o = CNT_WIDTH'(wr_ptr - rd_ptr);

    // Pointer update; flush empties the queue by catching rd up to wr.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (ctrl2ifq_flush_i) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage array carries no reset; contents are only observable via pointers.
    always_ff @(posedge clk_i) begin
        if (push_c && !rst_i) begin
            inst_mem[wr_ptr[AW-1:0]] <= pfu2ifq_inst_i;
            pc_mem[wr_ptr[AW-1:0]]   <= pfu2ifq_pc_i;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model plus directed scenarios.
module tb_inst_fetch_queue;
    import inst_fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned IW    = 32;
    localparam int unsigned PCW   = 32;
    localparam int unsigned CW    = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          pfu2ifq_valid_i;
    logic [IW-1:0] pfu2ifq_inst_i;
    logic [PCW-1:0] pfu2ifq_pc_i;
    logic          ifq2pfu_ready_o;
    logic          ifq2dpu_valid_o;
    logic [IW-1:0] ifq2dpu_inst_o;
    logic [PCW-1:0] ifq2dpu_pc_o;
    logic          dpu2ifq_ready_i;
    logic          ctrl2ifq_flush_i;
    logic          ifq2ctrl_empty_o;
    logic [CW-1:0] ifq2ctrl_count_o;

    always #5 clk_i = ~clk_i;

    inst_fetch_queue #(
        .DEPTH(DEPTH), .INST_WIDTH(IW), .PC_WIDTH(PCW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .pfu2ifq_valid_i (pfu2ifq_valid_i),
        .pfu2ifq_inst_i  (pfu2ifq_inst_i),
        .pfu2ifq_pc_i    (pfu2ifq_pc_i),
        .ifq2pfu_ready_o (ifq2pfu_ready_o),
        .ifq2dpu_valid_o (ifq2dpu_valid_o),
        .ifq2dpu_inst_o  (ifq2dpu_inst_o),
        .ifq2dpu_pc_o    (ifq2dpu_pc_o),
        .dpu2ifq_ready_i (dpu2ifq_ready_i),
        .ctrl2ifq_flush_i(ctrl2ifq_flush_i),
        .ifq2ctrl_empty_o(ifq2ctrl_empty_o),
        .ifq2ctrl_count_o(ifq2ctrl_count_o)
    );

    typedef struct {
        logic [IW-1:0]  inst;
        logic [PCW-1:0] pc;
    } ent_t;

    ent_t        mq[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input logic v, input logic [IW-1:0] inst, input logic [PCW-1:0] pc,
                        input logic dr, input logic fl, input logic rs);
        logic   e_rdy, e_vld, e_empty;
        ent_t   e;
        @(negedge clk_i);
        rst_i            = rs;
        pfu2ifq_valid_i  = v;
        pfu2ifq_inst_i   = inst;
        pfu2ifq_pc_i     = pc;
        dpu2ifq_ready_i  = dr;
        ctrl2ifq_flush_i = fl;
        #1;
        e_empty = (mq.size() == 0);
        e_rdy   = (mq.size() < DEPTH) && !fl;
        e_vld   = !e_empty && !fl;
        chk("model_ready", 32'(ifq2pfu_ready_o), 32'(e_rdy));
        chk("model_valid", 32'(ifq2dpu_valid_o), 32'(e_vld));
        chk("model_empty", 32'(ifq2ctrl_empty_o), 32'(e_empty));
        chk("model_count", 32'(ifq2ctrl_count_o), 32'(mq.size()));
        chk("model_inst", ifq2dpu_inst_o, e_empty ? 32'h0 : mq[0].inst);
        chk("model_pc", ifq2dpu_pc_o, e_empty ? 32'h0 : mq[0].pc);
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (e_vld && dr) void'(mq.pop_front());
            if (v && e_rdy) begin
                e.inst = inst;
                e.pc   = pc;
                mq.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic dr);
        step(1'b0, '0, '0, dr, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [PCW-1:0] pc, input logic dr);
        step(1'b1, NOP_INST ^ pc, pc, dr, 1'b0, 1'b0);
    endtask

    initial begin
        rst_i = 1'b1; pfu2ifq_valid_i = 1'b0; pfu2ifq_inst_i = '0; pfu2ifq_pc_i = '0;
        dpu2ifq_ready_i = 1'b0; ctrl2ifq_flush_i = 1'b0;
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);

        // Reset then idle
        idle(1'b1);
        chk("rst_valid", 32'(ifq2dpu_valid_o), 32'd0);
        chk("rst_empty", 32'(ifq2ctrl_empty_o), 32'd1);
        chk("rst_count", 32'(ifq2ctrl_count_o), 32'd0);
        chk("rst_ready", 32'(ifq2pfu_ready_o), 32'd1);
        chk("rst_inst", ifq2dpu_inst_o, 32'd0);
        chk("rst_pc", ifq2dpu_pc_o, 32'd0);

        // Single entry, one-cycle latency, no fall-through
        step(1'b1, NOP_INST, INIT_PC, 1'b0, 1'b0, 1'b0);
        chk("no_fallthru_valid", 32'(ifq2dpu_valid_o), 32'd0);
        idle(1'b0);
        chk("one_valid", 32'(ifq2dpu_valid_o), 32'd1);
        chk("one_inst", ifq2dpu_inst_o, 32'h0000_0013);
        chk("one_pc", ifq2dpu_pc_o, 32'h8000_0000);
        chk("one_count", 32'(ifq2ctrl_count_o), 32'd1);
        idle(1'b1);
        idle(1'b1);
        chk("one_drained", 32'(ifq2ctrl_empty_o), 32'd1);

        // Full queue: fifth offer waits until the cycle after a pop
        for (int i = 0; i < 4; i++) push(32'(i * 4), 1'b0);
        push(32'h10, 1'b0);
        chk("full_count", 32'(ifq2ctrl_count_o), 32'd4);
        chk("full_ready", 32'(ifq2pfu_ready_o), 32'd0);
        push(32'h10, 1'b1);
        chk("full_pop_pc", ifq2dpu_pc_o, 32'h0);
        chk("full_no_refill", 32'(ifq2pfu_ready_o), 32'd0);
        push(32'h10, 1'b0);
        chk("refill_ready", 32'(ifq2pfu_ready_o), 32'd1);
        chk("refill_count", 32'(ifq2ctrl_count_o), 32'd3);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("drain_order", ifq2dpu_pc_o, 32'((i + 1) * 4));
        end
        idle(1'b1);
        chk("drain_empty", 32'(ifq2ctrl_empty_o), 32'd1);

        // Streaming across pointer wraps
        push(32'h0, 1'b1);
        for (int i = 1; i < 10; i++) begin
            push(32'(i * 4), 1'b1);
            chk("stream_count", 32'(ifq2ctrl_count_o), 32'd1);
            chk("stream_pc", ifq2dpu_pc_o, 32'((i - 1) * 4));
        end
        idle(1'b1);
        chk("stream_last", ifq2dpu_pc_o, 32'h24);
        idle(1'b1);

        // Flush discards entries and the concurrent offer
        for (int i = 0; i < 3; i++) push(32'(i * 4), 1'b0);
        step(1'b1, 32'h20, 32'h20, 1'b1, 1'b1, 1'b0);
        chk("flush_ready", 32'(ifq2pfu_ready_o), 32'd0);
        chk("flush_valid", 32'(ifq2dpu_valid_o), 32'd0);
        push(32'h30, 1'b0);
        chk("post_flush_count", 32'(ifq2ctrl_count_o), 32'd0);
        chk("post_flush_valid", 32'(ifq2dpu_valid_o), 32'd0);
        chk("post_flush_ready", 32'(ifq2pfu_ready_o), 32'd1);
        idle(1'b0);
        chk("post_flush_pc", ifq2dpu_pc_o, 32'h30);
        idle(1'b1);

        // Reset beats push and flush
        push(32'h40, 1'b0);
        push(32'h44, 1'b0);
        step(1'b1, 32'h48, 32'h48, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        chk("rst2_valid", 32'(ifq2dpu_valid_o), 32'd0);
        chk("rst2_count", 32'(ifq2ctrl_count_o), 32'd0);
        chk("rst2_pc", ifq2dpu_pc_o, 32'd0);
        chk("rst2_ready", 32'(ifq2pfu_ready_o), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 127) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
